// File: rtl/syn_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Read-mode selectors and the occupancy counter width used by ports.
package syn_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Occupancy needs one extra bit so a full FIFO (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Simple dual-port storage, one write and one read port; read is registered (1 cycle) or async.
// No backpressure: the owner decides when we/re are legal.
module syn_fifo_ram #(
  parameter int data_width = 8,
  parameter int fifo_depth = 8,
  parameter bit reg_rd     = 1'b1,
  parameter int addr_w     = $clog2(fifo_depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_w-1:0]     waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  re,
  input  logic [addr_w-1:0]     raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [fifo_depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (reg_rd) begin : g_reg_rd
      logic [data_width-1:0] rdata_q;

      // Output register holds its value between reads; only it is reset, never the array.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (re) begin
          rdata_q <= mem[raddr];
        end
      end

      assign rdata = rdata_q;
    end else begin : g_async_rd
      // Disabled or in-reset port presents zeros rather than stale array contents.
      assign rdata = (re && rst_n) ? mem[raddr] : '0;
    end
  endgenerate

endmodule

// File: rtl/syn_fifo_param.sv
// Parametrised synchronous FIFO; std read 1-cycle latency, FWFT head visible 1 cycle after write.
// Writes when full are dropped (ovf_fg) unless a read frees the slot; reads when empty set udf_fg.
module syn_fifo_param
  import syn_fifo_pkg::*;
#(
  parameter int data_width = 8,
  parameter int fifo_depth = 8,
  parameter int afull_thr  = fifo_depth - 2,
  parameter int aempty_thr = 2,
  parameter int fwft       = FIFO_STD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [data_width-1:0]          wdata,
  input  logic                           rd_en,
  output logic [data_width-1:0]          rdata,
  output logic                           rvalid,
  output logic                           ful_fg,
  output logic                           emp_fg,
  output logic                           afull_fg,
  output logic                           aemp_fg,
  output logic [cnt_w(fifo_depth)-1:0]   count,
  output logic                           ovf_fg,
  output logic                           udf_fg
);

  localparam int addr_w = $clog2(fifo_depth);
  localparam int cw     = cnt_w(fifo_depth);

  localparam logic [cw-1:0] DEPTH_C  = cw'(fifo_depth);
  localparam logic [cw-1:0] AFULL_C  = cw'(afull_thr);
  localparam logic [cw-1:0] AEMPTY_C = cw'(aempty_thr);

  logic [addr_w-1:0]     wr_ptr;
  logic [addr_w-1:0]     rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [cw-1:0]         count_nxt;
  logic                  rvalid_q;
  logic                  ram_re;
  logic [data_width-1:0] ram_rdata;

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  always_comb begin
    rd_accept = rd_en && !emp_fg;
    wr_accept = wr_en && (!ful_fg || rd_accept);
    count_nxt = count;
    if (wr_accept && !rd_accept) begin
      count_nxt = count + cw'(1);
    end else if (!wr_accept && rd_accept) begin
      count_nxt = count - cw'(1);
    end
  end

  // Flags are computed from count_nxt so they never lag the registered count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ful_fg   <= 1'b0;
      emp_fg   <= 1'b1;
      afull_fg <= 1'b0;
      aemp_fg  <= 1'b1;
      ovf_fg   <= 1'b0;
      udf_fg   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + addr_w'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + addr_w'(1);
      end
      count    <= count_nxt;
      ful_fg   <= (count_nxt == DEPTH_C);
      emp_fg   <= (count_nxt == '0);
      afull_fg <= (count_nxt >= AFULL_C);
      aemp_fg  <= (count_nxt <= AEMPTY_C);
      ovf_fg   <= ovf_fg || (wr_en && !wr_accept);
      udf_fg   <= udf_fg || (rd_en && emp_fg);
      rvalid_q <= rd_accept;
    end
  end

  // FWFT keeps the async port enabled whenever a head word exists.
  assign ram_re = (fwft == FIFO_FWFT) ? !emp_fg : rd_accept;

  syn_fifo_ram #(
    .data_width (data_width),
    .fifo_depth (fifo_depth),
    .reg_rd     (fwft != FIFO_FWFT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rdata  = ram_rdata;
  assign rvalid = (fwft == FIFO_FWFT) ? !emp_fg : rvalid_q;

endmodule

// File: tb/tb_syn_fifo_param.sv
// Bench for syn_fifo_param: a standard-mode and an FWFT instance share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_syn_fifo_param;

  localparam int W = 8;
  localparam int D = 8;
  localparam int CW = $clog2(D) + 1;
  localparam int AFULL = D - 2;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  wdata = '0;

  logic [W-1:0]  s_rdata, f_rdata;
  logic          s_rvalid, f_rvalid;
  logic          s_ful, f_ful, s_emp, f_emp;
  logic          s_afull, f_afull, s_aemp, f_aemp;
  logic [CW-1:0] s_count, f_count;
  logic          s_ovf, f_ovf, s_udf, f_udf;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] q[$];
  bit           m_ovf, m_udf, m_rvalid;
  logic [W-1:0] m_rdata;
  logic [W-1:0] ctr;

  always #5 clk = ~clk;

  syn_fifo_param #(.data_width(W), .fifo_depth(D), .fwft(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(s_rdata), .rvalid(s_rvalid), .ful_fg(s_ful), .emp_fg(s_emp),
    .afull_fg(s_afull), .aemp_fg(s_aemp), .count(s_count),
    .ovf_fg(s_ovf), .udf_fg(s_udf)
  );

  syn_fifo_param #(.data_width(W), .fifo_depth(D), .fwft(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(f_rdata), .rvalid(f_rvalid), .ful_fg(f_ful), .emp_fg(f_emp),
    .afull_fg(f_afull), .aemp_fg(f_aemp), .count(f_count),
    .ovf_fg(f_ovf), .udf_fg(f_udf)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour from the FIFO rules, applied at each rising edge.
  task automatic model_step();
    bit rd_ok, wr_ok;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rvalid = 0; m_rdata = '0;
      return;
    end
    rd_ok = rd_en && (q.size() > 0);
    wr_ok = wr_en && ((q.size() < D) || rd_ok);
    if (rd_en && q.size() == 0) m_udf = 1;
    if (wr_en && !wr_ok) m_ovf = 1;
    m_rvalid = rd_ok;
    if (rd_ok) m_rdata = q.pop_front();
    if (wr_ok) q.push_back(wdata);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_count", s_count, n);   chk("f_count", f_count, n);
    chk("s_ful", s_ful, n == D);  chk("f_ful", f_ful, n == D);
    chk("s_emp", s_emp, n == 0);  chk("f_emp", f_emp, n == 0);
    chk("s_afull", s_afull, n >= AFULL);  chk("f_afull", f_afull, n >= AFULL);
    chk("s_aemp", s_aemp, n <= AEMPTY);   chk("f_aemp", f_aemp, n <= AEMPTY);
    chk("s_ovf", s_ovf, m_ovf);   chk("f_ovf", f_ovf, m_ovf);
    chk("s_udf", s_udf, m_udf);   chk("f_udf", f_udf, m_udf);
    chk("s_rvalid", s_rvalid, m_rvalid);
    chk("s_rdata", s_rdata, m_rdata);
    chk("f_rvalid", f_rvalid, n > 0);
    chk("f_rdata", f_rdata, (n > 0) ? q[0] : 0);
  endtask

  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w; wdata = d; rd_en = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_count", s_count, 0);
    chk("rst_emp", s_emp, 1);
    chk("rst_rdata", s_rdata, 0);

    // Fill with 0x00..0x07
    for (int i = 0; i < D; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      chk("fill_count", s_count, i + 1);
      chk("fill_afull", s_afull, (i + 1) >= 6);
      chk("fill_aemp", s_aemp, (i + 1) <= 2);
    end
    chk("fill_full", s_ful, 1);

    // Drain in order, each read answered by an rvalid pulse
    for (int i = 0; i < D; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("drain_rdata", s_rdata, i);
      chk("drain_rvalid", s_rvalid, 1);
    end
    cyc(1'b0, '0, 1'b0);
    chk("drain_rvalid_low", s_rvalid, 0);
    chk("drain_emp", s_emp, 1);
    chk("drain_no_err", {s_ovf, s_udf}, 0);

    // Overflow then underflow, both sticky until reset
    do_reset();
    for (int i = 0; i < D + 1; i++) cyc(1'b1, W'(8'h20 + i), 1'b0);
    chk("ovf_set", s_ovf, 1);
    for (int i = 0; i < D; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("ovf_readback", s_rdata, 8'h20 + i);
    end
    cyc(1'b0, '0, 1'b1);
    chk("udf_set", s_udf, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
    chk("sticky", {s_ovf, s_udf, f_ovf, f_udf}, 4'hF);
    do_reset();
    chk("sticky_clr", {s_ovf, s_udf}, 0);

    // Simultaneous read/write when full and when empty
    for (int i = 0; i < D; i++) cyc(1'b1, W'(8'h30 + i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("full_rw_count", s_count, D);
    chk("full_rw_ovf", s_ovf, 0);
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1);
    chk("full_rw_last", s_rdata, 8'hAA);
    cyc(1'b1, 8'h55, 1'b1);
    chk("empty_rw_count", s_count, 1);
    chk("empty_rw_udf", s_udf, 1);

    // First-word-fall-through
    do_reset();
    cyc(1'b1, 8'h11, 1'b0);
    chk("fwft_rdata", f_rdata, 8'h11);
    chk("fwft_rvalid", f_rvalid, 1);
    cyc(1'b0, '0, 1'b1);
    chk("fwft_pop_emp", f_emp, 1);

    // Random traffic across pointer wrap, data = running counter
    do_reset();
    ctr = '0;
    for (int i = 0; i < 80; i++) begin
      cyc($urandom_range(0, 99) < 60, ctr, $urandom_range(0, 99) < 50);
      ctr++;
    end
    for (int i = 0; i < D && q.size() < 5; i++) begin
      cyc(1'b1, ctr, 1'b0);
      ctr++;
    end
    for (int i = 0; i < D && q.size() > 5; i++) cyc(1'b0, '0, 1'b1);
    chk("pre_rst_count", s_count, 5);
    do_reset();
    chk("mid_rst_count", s_count, 0);
    chk("mid_rst_emp", s_emp, 1);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b1, 8'h78, 1'b0);
    chk("post_rst_fwft_head", f_rdata, 8'h77);
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_first", s_rdata, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
